// File: rtl/accel_pkg.sv
// Shared definitions for the math accelerator register interface:
// register map, opcode encodings and the command-master state encoding.
package accel_pkg;

  // Peripheral register map
  localparam logic [3:0] ADDR_A      = 4'h0;
  localparam logic [3:0] ADDR_B      = 4'h1;
  localparam logic [3:0] ADDR_OP     = 4'h4;
  localparam logic [3:0] ADDR_RES_LO = 4'h5;
  localparam logic [3:0] ADDR_RES_HI = 4'h6;

  // Opcodes understood by the peripheral; anything else yields 0x0000
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_OP,
    ST_WR_CAP,
    ST_RD_LO,
    ST_RD_HI,
    ST_RESP
  } state_t;

  // First operand write still to be issued, in bus order A, B, Op;
  // when every operand write is skipped the capture write comes next.
  function automatic state_t first_write(input logic skip_a,
                                         input logic skip_b,
                                         input logic skip_op);
    if (!skip_a)       return ST_WR_A;
    else if (!skip_b)  return ST_WR_B;
    else if (!skip_op) return ST_WR_OP;
    else               return ST_WR_CAP;
  endfunction

endpackage

// File: rtl/accel_cmd_master.sv
// Bus initiator for the math accelerator peripheral. Takes one job
// (A, B, opcode), writes the operand registers (skipping ones the
// peripheral already holds when the write cache is enabled), issues the
// result-capture write, reads both result bytes and returns the result.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised, stays high with stable payload until
// that transfer. cmd_ready is high only in IDLE; rsp_valid is high only
// in RESP.
module accel_cmd_master
  import accel_pkg::*;
#(
  parameter bit         CACHE_EN = 1'b1,
  parameter logic [3:0] CAP_ADDR = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [3:0]  cmd_op,
  input  logic        cache_inv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  bus_addr,
  output logic        bus_write,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);

  state_t      state;
  state_t      state_nxt;

  // Latched job and the skip decisions taken at accept time
  logic [7:0]  job_a;
  logic [7:0]  job_b;
  logic [3:0]  job_op;
  logic        skip_b_q;
  logic        skip_op_q;
  logic        job_full;
  logic        inv_seen;

  // Last values written to the peripheral since reset / invalidate
  logic [7:0]  cache_a;
  logic [7:0]  cache_b;
  logic [3:0]  cache_op;
  logic        cache_valid;

  logic        accept;
  logic        cache_hit;
  logic        hit_a;
  logic        hit_b;
  logic        hit_op;

  logic [3:0]  addr_nxt;
  logic        write_nxt;
  logic [7:0]  wdata_nxt;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // An invalidate in the accept cycle wins over a cache hit
  assign cache_hit = CACHE_EN && cache_valid && !cache_inv;
  assign hit_a     = cache_hit && (cmd_a  == cache_a);
  assign hit_b     = cache_hit && (cmd_b  == cache_b);
  assign hit_op    = cache_hit && (cmd_op == cache_op);

  // Next-state selection for the job sequence
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = first_write(hit_a, hit_b, hit_op);
      ST_WR_A:   state_nxt = first_write(1'b1, skip_b_q, skip_op_q);
      ST_WR_B:   state_nxt = first_write(1'b1, 1'b1, skip_op_q);
      ST_WR_OP:  state_nxt = ST_WR_CAP;
      ST_WR_CAP: state_nxt = ST_RD_LO;
      ST_RD_LO:  state_nxt = ST_RD_HI;
      ST_RD_HI:  state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Bus values for the state being entered, so the bus outputs are
  // registered and line up with the state they belong to
  always_comb begin
    addr_nxt  = 4'h0;
    write_nxt = 1'b0;
    wdata_nxt = 8'h00;
    case (state_nxt)
      ST_WR_A: begin
        addr_nxt  = ADDR_A;
        write_nxt = 1'b1;
        wdata_nxt = cmd_a;  // WR_A is only ever entered from IDLE
      end
      ST_WR_B: begin
        addr_nxt  = ADDR_B;
        write_nxt = 1'b1;
        wdata_nxt = (state == ST_IDLE) ? cmd_b : job_b;
      end
      ST_WR_OP: begin
        addr_nxt  = ADDR_OP;
        write_nxt = 1'b1;
        wdata_nxt = {4'b0000, ((state == ST_IDLE) ? cmd_op : job_op)};
      end
      ST_WR_CAP: begin
        addr_nxt  = CAP_ADDR;
        write_nxt = 1'b1;
        wdata_nxt = 8'h00;
      end
      ST_RD_LO: addr_nxt = ADDR_RES_LO;
      ST_RD_HI: addr_nxt = ADDR_RES_HI;
      default: ;
    endcase
  end

  // State, registered bus/response outputs, job latch and write cache
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bus_addr    <= 4'h0;
      bus_write   <= 1'b0;
      bus_wdata   <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_result  <= 16'h0000;
      job_a       <= 8'h00;
      job_b       <= 8'h00;
      job_op      <= 4'h0;
      skip_b_q    <= 1'b0;
      skip_op_q   <= 1'b0;
      job_full    <= 1'b0;
      inv_seen    <= 1'b0;
      cache_a     <= 8'h00;
      cache_b     <= 8'h00;
      cache_op    <= 4'h0;
      cache_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_addr  <= addr_nxt;
      bus_write <= write_nxt;
      bus_wdata <= wdata_nxt;
      rsp_valid <= (state_nxt == ST_RESP);

      if (accept) begin
        job_a     <= cmd_a;
        job_b     <= cmd_b;
        job_op    <= cmd_op;
        skip_b_q  <= hit_b;
        skip_op_q <= hit_op;
        job_full  <= !(hit_a || hit_b || hit_op);
      end

      // An invalidate while a full job is in flight keeps the cache
      // invalid even after that job finishes its writes
      if (accept)         inv_seen <= 1'b0;
      else if (cache_inv) inv_seen <= 1'b1;

      case (state)
        ST_WR_A:  cache_a  <= job_a;
        ST_WR_B:  cache_b  <= job_b;
        ST_WR_OP: cache_op <= job_op;
        ST_RD_LO: rsp_result[7:0]  <= bus_rdata;
        ST_RD_HI: rsp_result[15:8] <= bus_rdata;
        default: ;
      endcase

      // Single valid bit: set only once all three entries were written
      if (cache_inv)
        cache_valid <= 1'b0;
      else if (state == ST_WR_OP && job_full && !inv_seen)
        cache_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accel_cmd_master.sv
// Directed bench for accel_cmd_master with a behavioural model of the
// math accelerator peripheral attached to the register bus.
module tb_accel_cmd_master;
  import accel_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [3:0]  cmd_op;
  logic        cache_inv;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  bus_addr;
  logic        bus_write;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] exp_q[$];
  logic [11:0] exp_wr_q[$];
  logic [11:0] wr_q[$];
  int          wr_cyc_q[$];

  accel_cmd_master dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cache_inv  (cache_inv),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .bus_addr   (bus_addr),
    .bus_write  (bus_write),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // ---------------- peripheral model ----------------
  logic [7:0]  p_a   = 8'h00;
  logic [7:0]  p_b   = 8'h00;
  logic [3:0]  p_op  = 4'h0;
  logic [15:0] p_res = 16'h0000;

  function automatic logic [15:0] alu(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] op);
    case (op)
      4'd0: return {8'h00, a} + {8'h00, b};
      4'd1: return {8'h00, a} - {8'h00, b};
      4'd2: return {8'h00, a} * {8'h00, b};
      4'd3: return (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
      4'd4: return {8'h00, a & b};
      4'd5: return {8'h00, a | b};
      4'd6: return {8'h00, a ^ b};
      default: return 16'h0000;
    endcase
  endfunction

  // Result register loads from the held operands on every write strobe
  always @(posedge clk) begin
    if (bus_write) begin
      p_res <= alu(p_a, p_b, p_op);
      case (bus_addr)
        4'h0: p_a  <= bus_wdata;
        4'h1: p_b  <= bus_wdata;
        4'h4: p_op <= bus_wdata[3:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_rdata = 8'h00;
    if (bus_addr == 4'h5) bus_rdata = p_res[7:0];
    else if (bus_addr == 4'h6) bus_rdata = p_res[15:8];
  end

  // Bus write monitor
  always @(negedge clk) begin
    cyc++;
    if (rst_n && bus_write) begin
      wr_q.push_back({bus_addr, bus_wdata});
      wr_cyc_q.push_back(cyc);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // wmask bits: [2] A write expected, [1] B write, [0] Op write
  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [2:0] wmask, input logic [15:0] res,
                         input int exp_lat, input int hold, input logic inv);
    int lat;
    logic [11:0] e;
    logic [11:0] g;
    int n_wr;
    @(negedge clk);
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cache_inv = inv;
    exp_q.push_back(res);
    if (wmask[2]) exp_wr_q.push_back({ADDR_A, a});
    if (wmask[1]) exp_wr_q.push_back({ADDR_B, b});
    if (wmask[0]) exp_wr_q.push_back({ADDR_OP, 4'h0, op});
    exp_wr_q.push_back({4'hF, 8'h00});
    wr_q.delete();
    wr_cyc_q.delete();

    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cache_inv = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    check("latency", lat, exp_lat);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_rsp_result", {16'b0, rsp_result}, {16'b0, exp_q[0]});
      check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end

    @(negedge clk);
    rsp_ready = 1'b1;
    check("rsp_result", {16'b0, rsp_result}, {16'b0, exp_q.pop_front()});
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_valid_clear", {31'b0, rsp_valid}, 32'd0);
    check("cmd_ready_back", {31'b0, cmd_ready}, 32'd1);

    n_wr = exp_wr_q.size();
    check("wr_count", wr_q.size(), n_wr);
    while (exp_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      g = (wr_q.size() > 0) ? wr_q.pop_front() : 12'hxxx;
      check("wr_seq", {20'b0, g}, {20'b0, e});
    end
    if (wr_cyc_q.size() > 0)
      check("wr_consecutive", wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0], wr_cyc_q.size() - 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    cmd_op    = 4'h0;
    cache_inv = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_bus_addr",   {28'b0, bus_addr},   32'd0);
    check("rst_bus_write",  {31'b0, bus_write},  32'd0);
    check("rst_bus_wdata",  {24'b0, bus_wdata},  32'd0);
    check("rst_rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("rst_rsp_result", {16'b0, rsp_result}, 32'd0);
    check("rst_cmd_ready",  {31'b0, cmd_ready},  32'd1);
    rst_n = 1'b1;

    // Cold cache: full write sequence
    run_job(8'd200, 8'd100, OP_ADD, 3'b111, 16'h012C, 7, 0, 1'b0);
    // A and B cached: only Op and capture
    run_job(8'd200, 8'd100, OP_MUL, 3'b001, 16'h4E20, 5, 0, 1'b0);
    // Identical job: capture only
    run_job(8'd200, 8'd100, OP_MUL, 3'b000, 16'h4E20, 4, 0, 1'b0);
    // Op cached from the previous job
    run_job(8'd255, 8'd255, OP_MUL, 3'b110, 16'hFE01, 6, 0, 1'b0);
    run_job(8'd7,   8'd0,   OP_DIV, 3'b111, 16'hFFFF, 7, 0, 1'b0);

    // One-cycle invalidate, then identical job does every write
    @(negedge clk);
    cache_inv = 1'b1;
    @(negedge clk);
    cache_inv = 1'b0;
    run_job(8'd7, 8'd0, OP_DIV, 3'b111, 16'hFFFF, 7, 0, 1'b0);

    // Response stalled for 10 cycles
    run_job(8'hF0, 8'h3C, OP_AND, 3'b111, 16'h0030, 7, 10, 1'b0);
    // Invalidate in the accept cycle overrides a full cache hit
    run_job(8'hF0, 8'h3C, OP_AND, 3'b111, 16'h0030, 7, 0, 1'b1);
    // Undefined opcode passes through; peripheral returns zero
    run_job(8'hF0, 8'h3C, 4'hA, 3'b001, 16'h0000, 5, 0, 1'b0);

    // Reset during WR_B
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a     = 8'd5;
    cmd_b     = 8'd9;
    cmd_op    = OP_SUB;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_wr_b_addr",  {28'b0, bus_addr},  32'd1);
    check("pre_rst_wr_b_write", {31'b0, bus_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_bus_addr",   {28'b0, bus_addr},   32'd0);
    check("arst_bus_write",  {31'b0, bus_write},  32'd0);
    check("arst_bus_wdata",  {24'b0, bus_wdata},  32'd0);
    check("arst_rsp_valid",  {31'b0, rsp_valid},  32'd0);
    check("arst_rsp_result", {16'b0, rsp_result}, 32'd0);
    check("arst_cmd_ready",  {31'b0, cmd_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(8'd5, 8'd9, OP_SUB, 3'b111, 16'hFFFC, 7, 0, 1'b0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_cmd_master.md
Name: accel_cmd_master

Overview:
- Bus initiator for the math accelerator peripheral's register interface; drives the same address/data_write/data_in/data_out bus that the TinyQV core would drive.
- Accepts a job (A, B, opcode) on a valid/ready command port, then runs the peripheral's register write sequence, the result-capture write and both result reads.
- Returns the 16-bit result on a valid/ready response port.
- Used for autonomous operation and as a bench driver for the peripheral.

Parameters:
- CACHE_EN, 1, when 1 skip writes of A/B/Op whose value equals the last value written since reset or invalidate.
- CAP_ADDR, 4'hF, unmapped peripheral address used for the result-capture write; must not be 0x0/0x1/0x4.

Ports:
- clk  in  1  project clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- cmd_op  in  4  opcode; 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor; others pass through unchanged
- cache_inv  in  1  invalidate write cache
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_result  out  16  result
- bus_addr  out  4  peripheral address, registered
- bus_write  out  1  write strobe, registered
- bus_wdata  out  8  write data, registered
- bus_rdata  in  8  peripheral data_out; combinational function of bus_addr

Behaviour:
- Reset values (asynchronous): state IDLE, bus_addr 0, bus_write 0, bus_wdata 0, rsp_valid 0, rsp_result 0, cache invalid. cmd_ready is combinational from state and is 1 after reset.
- Capture rule: the peripheral loads its result register from the currently held A/B/Op on every write strobe. A capture write to CAP_ADDR is therefore mandatory after the last operand write.
- States: IDLE, WR_A, WR_B, WR_OP, WR_CAP, RD_LO, RD_HI, RESP.
- IDLE: on cmd_valid && cmd_ready, latch cmd_a/b/op.
  - Next state is the first of WR_A, WR_B, WR_OP that is not skipped, else WR_CAP.
  - A write is skipped only if CACHE_EN=1, the cache is valid, and the latched value equals the cached value.
- WR_A / WR_B / WR_OP: hold exactly one cycle with bus_write=1, bus_addr 0x0 / 0x1 / 0x4, bus_wdata = A / B / {4'b0, op}. Update the cache entry. Advance to the next non-skipped write, else WR_CAP.
- WR_CAP: one cycle with bus_write=1, bus_addr=CAP_ADDR, bus_wdata=0.
- RD_LO: bus_write=0, bus_addr=0x5. Sample bus_rdata into rsp_result[7:0] at the end of this cycle.
- RD_HI: bus_addr=0x6. Sample bus_rdata into rsp_result[15:8].
- RESP: rsp_valid=1; rsp_result is held stable. On rsp_ready, return to IDLE and clear rsp_valid on the same edge. rsp_valid never drops without rsp_ready.
- Latency (accept edge to rsp_valid): 7 cycles with no skips; 4 cycles with all three writes skipped. Back-to-back jobs allow at most one IDLE cycle between them.
- bus_write is 0 in IDLE, RD_LO, RD_HI and RESP.
- Cache:
  - Becomes valid after the first complete WR_OP, or after a job whose three entries were all written.
  - Per-entry validity is acceptable; the simplest correct choice is a single valid bit that is set only when all three entries have been written.
  - cache_inv clears validity in any state. If cache_inv is asserted in the accept cycle, it takes precedence and that job performs all writes.
  - cache_inv during a write state does not abort that state.
- Arithmetic is performed entirely by the peripheral; this block performs no computation. The divide-by-zero result 0xFFFF and the 0x0000 returned for undefined opcodes pass through unmodified.
- Reset mid-operation returns to IDLE immediately and invalidates the cache. The peripheral's register contents are then undefined to this block.

Decomposition:
- Shared package accel_pkg: register address constants (ADDR_A 0x0, ADDR_B 0x1, ADDR_OP 0x4, ADDR_RES_LO 0x5, ADDR_RES_HI 0x6), opcode constants (ADD..XOR), and the state enum.
- Single module; no sub-module is needed. The cache compare is inline logic.

Test Plan:
- Add job A=200, B=100, op=0 after reset, peripheral attached. Required: writes at 0x0, 0x1, 0x4, 0xF on consecutive cycles; rsp_result 0x012C; rsp_valid 7 cycles after accept.
- Mul 255×255, then div 7/0. Required: 0xFE01, then 0xFFFF.
- Repeat A=200, B=100 with op=2. Required: only writes 0x4 and 0xF; result 0x4E20; latency 5. Identical job repeated: only the 0xF write; latency 4.
- Assert cache_inv for one cycle, then send an identical job. Required: all four writes issued.
- Hold rsp_ready=0 for 10 cycles. Required: rsp_valid and rsp_result stable; cmd_ready=0 throughout; handshake completes on the first rsp_ready=1 cycle.
- Assert rst_n low during WR_B. Required: all outputs at reset values asynchronously. The next job issues the full write sequence and returns the correct result (sub 5-9 = 0xFFFC).
